// File: rtl/pipeline_control.sv
// pipeline_control: stall/flush/halt sequencer for a simple in-order core.
// One four-state FSM decides, cycle by cycle, whether the front end is
// held (load latency), invalidated (taken jump) or stopped for good (HALT).
// Optional performance counters are compiled in with `define PIPE_PERF_CNT_EN.
module pipeline_control #(
    parameter int unsigned LOAD_LAT     = 1,   // 1..15 extra stall cycles per load
    parameter int unsigned FLUSH_CYCLES = 2,   // 1..3 bubble cycles after a jump
    parameter int unsigned CNT_W        = 16   // performance counter width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_req,
    input  logic             jump_taken,
    input  logic             halt_req,
    output logic             stall_front,
    output logic             bubble_exec,
    output logic             flush_front,
    output logic             halted,
    output logic [1:0]       state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] halt_cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        FLUSH     = 2'd2,
        HALT      = 2'd3
    } state_t;

    // The counter holds the remaining cycles after the current one, so the
    // entry cycle in RUN plus LAT/FLUSH cycles in the wait state gives N+1.
    localparam logic [3:0] LOAD_INIT  = 4'(LOAD_LAT - 1);
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       stall_raw, bubble_raw, flush_raw, halted_raw;

    // State and wait counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state selection and raw control outputs; RUN is Mealy on the requests.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_raw  = 1'b0;
        bubble_raw = 1'b0;
        flush_raw  = 1'b0;
        halted_raw = 1'b0;
        case (state)
            RUN: begin
                if (halt_req) begin
                    stall_raw  = 1'b1;
                    state_next = HALT;
                end else if (jump_taken) begin
                    flush_raw  = 1'b1;
                    state_next = FLUSH;
                    cnt_next   = FLUSH_INIT;
                end else if (load_req) begin
                    stall_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    state_next = LOAD_WAIT;
                    cnt_next   = LOAD_INIT;
                end
            end
            LOAD_WAIT: begin
                stall_raw  = 1'b1;
                bubble_raw = 1'b1;
                if (cnt == 4'd0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            FLUSH: begin
                flush_raw  = 1'b1;
                bubble_raw = 1'b1;
                if (cnt == 4'd0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            HALT: begin
                stall_raw  = 1'b1;
                bubble_raw = 1'b1;
                halted_raw = 1'b1;
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // Reset masks the Mealy outputs so they drop without waiting for an edge.
    always_comb begin
        stall_front = stall_raw  & ~reset;
        bubble_exec = bubble_raw & ~reset;
        flush_front = flush_raw  & ~reset;
        halted      = halted_raw & ~reset;
        state_o     = state;
    end

`ifdef PIPE_PERF_CNT_EN
    logic load_stall;

    // A stall is load-caused in LOAD_WAIT or on a winning load request in RUN.
    always_comb begin
        load_stall = (state == LOAD_WAIT) ||
                     ((state == RUN) && load_req && !jump_taken && !halt_req);
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_stall_cnt <= '0;
            flush_cnt      <= '0;
            halt_cycle_cnt <= '0;
        end else begin
            if (load_stall && (load_stall_cnt != '1)) begin
                load_stall_cnt <= load_stall_cnt + CNT_W'(1);
            end
            if (flush_raw && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (halted_raw && (halt_cycle_cnt != '1)) begin
                halt_cycle_cnt <= halt_cycle_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Testbench for pipeline_control: two instances (LOAD_LAT=1/FLUSH=2/CNT_W=4 and
// LOAD_LAT=3/FLUSH=3/CNT_W=16) share stimulus and are checked every cycle
// against a burst-schedule reference model. Define PIPE_PERF_CNT_EN to
// include the performance counters.
`timescale 1ns/1ps
module tb_pipeline_control;

    logic clk = 1'b0;
    logic reset, load_req, jump_taken, halt_req;

    logic stall_a, bubble_a, flush_a, halted_a;
    logic stall_b, bubble_b, flush_b, halted_b;
    logic [1:0] st_a, st_b;
`ifdef PIPE_PERF_CNT_EN
    logic [3:0]  lc_a, fc_a, hc_a;
    logic [15:0] lc_b, fc_b, hc_b;
`endif

    always #5 clk = ~clk;

    pipeline_control #(.LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_W(4)) u_dut_a (
        .clk(clk), .reset(reset), .load_req(load_req), .jump_taken(jump_taken),
        .halt_req(halt_req), .stall_front(stall_a), .bubble_exec(bubble_a),
        .flush_front(flush_a), .halted(halted_a), .state_o(st_a)
`ifdef PIPE_PERF_CNT_EN
        , .load_stall_cnt(lc_a), .flush_cnt(fc_a), .halt_cycle_cnt(hc_a)
`endif
    );

    pipeline_control #(.LOAD_LAT(3), .FLUSH_CYCLES(3), .CNT_W(16)) u_dut_b (
        .clk(clk), .reset(reset), .load_req(load_req), .jump_taken(jump_taken),
        .halt_req(halt_req), .stall_front(stall_b), .bubble_exec(bubble_b),
        .flush_front(flush_b), .halted(halted_b), .state_o(st_b)
`ifdef PIPE_PERF_CNT_EN
        , .load_stall_cnt(lc_b), .flush_cnt(fc_b), .halt_cycle_cnt(hc_b)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an idle core starts a fixed-length burst for the winning
    // request; while a burst runs or the core is halted, requests are ignored.
    localparam int KIND_LOAD  = 1;
    localparam int KIND_FLUSH = 2;
    int unsigned lat[2]  = '{1, 3};
    int unsigned fcy[2]  = '{2, 3};
    int unsigned cmax[2] = '{15, 65535};

    int  rem[2], kind[2], nx_rem[2], nx_kind[2];
    bit  hlt[2], nx_hlt[2];
    int  pl[2], pf[2], ph[2];
    logic [3:0] e_out[2];   // {stall, bubble, flush, halted}
    logic [1:0] e_st[2];
    bit  e_ld[2];

    int n_stall_a, n_flush_a, n_halt_a, n_stall_b;

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; kind[k] = 0; hlt[k] = 0;
            pl[k] = 0; pf[k] = 0; ph[k] = 0;
        end
    endtask

    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            e_out[k] = 4'b0000; e_st[k] = 2'd0; e_ld[k] = 0;
            nx_rem[k] = rem[k]; nx_kind[k] = kind[k]; nx_hlt[k] = hlt[k];
            if (reset) begin
                nx_rem[k] = 0; nx_hlt[k] = 0;
            end else if (hlt[k]) begin
                e_out[k] = 4'b1101; e_st[k] = 2'd3;
            end else if (rem[k] > 0) begin
                nx_rem[k] = rem[k] - 1;
                if (kind[k] == KIND_LOAD) begin
                    e_out[k] = 4'b1100; e_st[k] = 2'd1; e_ld[k] = 1;
                end else begin
                    e_out[k] = 4'b0110; e_st[k] = 2'd2;
                end
            end else if (halt_req) begin
                e_out[k] = 4'b1000; nx_hlt[k] = 1;
            end else if (jump_taken) begin
                e_out[k] = 4'b0010; nx_rem[k] = fcy[k]; nx_kind[k] = KIND_FLUSH;
            end else if (load_req) begin
                e_out[k] = 4'b1100; e_ld[k] = 1; nx_rem[k] = lat[k]; nx_kind[k] = KIND_LOAD;
            end
        end
    endtask

    task automatic model_commit();
        for (int k = 0; k < 2; k++) begin
            rem[k] = nx_rem[k]; kind[k] = nx_kind[k]; hlt[k] = nx_hlt[k];
            if (reset) begin
                pl[k] = 0; pf[k] = 0; ph[k] = 0;
            end else begin
                if (e_ld[k]     && pl[k] < int'(cmax[k])) pl[k]++;
                if (e_out[k][1] && pf[k] < int'(cmax[k])) pf[k]++;
                if (e_out[k][0] && ph[k] < int'(cmax[k])) ph[k]++;
            end
        end
    endtask

    task automatic check_all();
        check_eq("outs_a",  {28'd0, stall_a, bubble_a, flush_a, halted_a}, {28'd0, e_out[0]});
        check_eq("state_a", {30'd0, st_a}, {30'd0, e_st[0]});
        check_eq("outs_b",  {28'd0, stall_b, bubble_b, flush_b, halted_b}, {28'd0, e_out[1]});
        check_eq("state_b", {30'd0, st_b}, {30'd0, e_st[1]});
`ifdef PIPE_PERF_CNT_EN
        check_eq("lcnt_a", {28'd0, lc_a}, 32'(pl[0]));
        check_eq("fcnt_a", {28'd0, fc_a}, 32'(pf[0]));
        check_eq("hcnt_a", {28'd0, hc_a}, 32'(ph[0]));
        check_eq("lcnt_b", {16'd0, lc_b}, 32'(pl[1]));
        check_eq("fcnt_b", {16'd0, fc_b}, 32'(pf[1]));
        check_eq("hcnt_b", {16'd0, hc_b}, 32'(ph[1]));
`endif
    endtask

    // One clock cycle: drive at negedge, check before the rising edge, advance model.
    task automatic cycle(input bit l, input bit j, input bit h, input bit r);
        @(negedge clk);
        load_req = l; jump_taken = j; halt_req = h; reset = r;
        if (r) model_clear();
        #1;
        model_eval();
        check_all();
        n_stall_a += int'(stall_a); n_flush_a += int'(flush_a);
        n_halt_a  += int'(halted_a); n_stall_b += int'(stall_b);
        @(posedge clk);
        model_commit();
    endtask

    task automatic clear_tallies();
        n_stall_a = 0; n_flush_a = 0; n_halt_a = 0; n_stall_b = 0;
    endtask

    initial begin
        reset = 1'b1; load_req = 0; jump_taken = 0; halt_req = 0;
        model_clear();
        clear_tallies();

        // Reset held with requests present: everything quiet.
        cycle(1, 0, 0, 1);
        cycle(0, 1, 1, 1);
        cycle(0, 0, 0, 0);

        // Single load pulse at LOAD_LAT=1: two stall/bubble cycles, then RUN.
        clear_tallies();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        check_eq("ld_stall_len_a", 32'(n_stall_a), 32'd2);
        check_eq("ld_stall_len_b", 32'(n_stall_b), 32'd4);
        check_eq("ld_end_state_a", {30'd0, st_a}, 32'd0);

        // Jump with load in the same cycle: flush only, three cycles.
        clear_tallies();
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        check_eq("jmp_flush_len_a", 32'(n_flush_a), 32'd3);
        check_eq("jmp_no_stall_a", 32'(n_stall_a), 32'd0);

        // LOAD_LAT=3: jump in second LOAD_WAIT cycle is ignored.
        clear_tallies();
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
        check_eq("lw_jump_ign_b", 32'(n_stall_b), 32'd4);

        // Reset in the middle of FLUSH drops outputs before any edge.
        cycle(0, 1, 0, 0);
        @(negedge clk);
        load_req = 0; jump_taken = 0; halt_req = 0;
        #1;
        check_eq("mid_flush_a", {31'd0, flush_a}, 32'd1);
        reset = 1'b1;
        model_clear();
        #1;
        check_eq("rst_outs_a", {28'd0, stall_a, bubble_a, flush_a, halted_a}, 32'd0);
        check_eq("rst_outs_b", {28'd0, stall_b, bubble_b, flush_b, halted_b}, 32'd0);
        check_eq("rst_state_a", {30'd0, st_a}, 32'd0);
        check_eq("rst_state_b", {30'd0, st_b}, 32'd0);
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);   // first edge after release behaves as RUN
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

        // Halt wins over jump; halted for 100 cycles with no flush.
        clear_tallies();
        cycle(0, 1, 1, 0);
        for (int i = 0; i < 100; i++)
            cycle(1'($urandom), 1'($urandom), 1'($urandom), 0);
        check_eq("halt_len_a", 32'(n_halt_a), 32'd100);
        check_eq("halt_no_flush_a", 32'(n_flush_a), 32'd0);
        cycle(0, 0, 0, 1);

        // Twenty back-to-back loads.
        for (int i = 0; i < 40; i++) cycle(1, 0, 0, 0);
`ifdef PIPE_PERF_CNT_EN
        check_eq("lcnt_sat_a", {28'd0, lc_a}, 32'd15);
`endif
        cycle(0, 0, 0, 1);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
